// File: rtl/ram_arbiter_pkg.sv
// Shared types for the unified-RAM arbiter: machine word, RAM handshake
// state and arbiter FSM state, plus a small request-decode helper.
package ram_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } arb_state_t;

    // Width of the fetch-starvation counter (STARVE_MAX tops out at 15)
    localparam int STARVE_W = 4;

    localparam word_t WORD_ZERO = 32'h0000_0000;

    // A data access is pending when either strobe is raised
    function automatic logic data_req(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of every requester-side and RAM-side signal of the arbiter.
// The arb modport is the arbiter's view, tb is the surrounding logic's view.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    // instruction fetch side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // data load/store side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ram_err;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

endinterface

// File: rtl/ram_arbiter_starve.sv
// Saturating count of data grants that completed while a fetch was waiting.
// Clear wins over increment; sat_o flags that the fetch must go next.
module starve_counter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic [STARVE_W-1:0] cnt_o,
    output logic                sat_o
);

    localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {STARVE_W{1'b0}};
        end else if (inc_i && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared asynchronously by RST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= {STARVE_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and
// data load/store. Data normally wins; after STARVE_MAX data grants with a
// fetch pending, the fetch is forced through. Every completion returns to
// IDLE for one cycle before the next grant.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    ram_arbiter_if.arb  bus
);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic                err_q;
    logic                err_d;
    logic                d_req_s;
    logic                i_done_s;
    logic                d_done_s;
    logic                starve_inc_s;
    logic                starve_clr_s;
    logic                starve_sat_s;
    logic [STARVE_W-1:0] starve_cnt_s;

    assign d_req_s = data_req(bus.dREN, bus.dWEN);

    // Starvation bookkeeping: data completions with a fetch waiting count up;
    // any fetch completion or a data completion with no fetch waiting resets
    assign starve_inc_s = d_done_s & bus.iREN;
    assign starve_clr_s = i_done_s | (d_done_s & ~bus.iREN);

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .CLK   (CLK),
        .RST   (RST),
        .inc_i (starve_inc_s),
        .clr_i (starve_clr_s),
        .cnt_o (starve_cnt_s),
        .sat_o (starve_sat_s)
    );

    // Grant-state register; reset abandons any grant in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and combinational RAM/requester outputs
    always_comb begin
        state_d      = state_q;
        i_done_s     = 1'b0;
        d_done_s     = 1'b0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = WORD_ZERO;
        bus.dload    = WORD_ZERO;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = WORD_ZERO;
        bus.ramstore = WORD_ZERO;
        case (state_q)
            IDLE: begin
                bus.iwait = bus.iREN;
                bus.dwait = d_req_s;
                if (bus.iREN && starve_sat_s) begin
                    state_d = IGRANT;
                end else if (d_req_s) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    // fetch withdrawn: drop the grant silently
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                    i_done_s  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    // FREE/BUSY wait, ERROR reissues the same request
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                // a simultaneous read and write request is performed as a write
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!d_req_s) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                    d_done_s  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = DGRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Error flag is sticky: any ERROR answer to a grant latches it
    always_comb begin
        err_d = err_q;
        if ((state_q != IDLE) && (bus.ramstate == ERROR)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky error register, cleared only by RST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.ram_err = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter. Stimulus pushes the expected
// completion of each request into a per-requester queue; a monitor pops and
// compares whenever a requester's wait drops while it is requesting.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    typedef struct packed {
        logic  wen;
        word_t addr;
        word_t wdata;
        word_t load;
    } exp_t;

    logic CLK;
    logic RST;
    int   vectors;
    int   errors;
    exp_t iq[$];
    exp_t dq[$];

    ram_arbiter_if bus ();

    ram_arbiter #(.STARVE_MAX(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    function automatic logic [31:0] st();
        return {30'd0, dut.state_q};
    endfunction

    function automatic logic [31:0] sc();
        return {28'd0, dut.u_starve.cnt_q};
    endfunction

    function automatic exp_t mk(input logic wen, input word_t a, input word_t w, input word_t l);
        exp_t e;
        e.wen = wen; e.addr = a; e.wdata = w; e.load = l;
        return e;
    endfunction

    // Monitor: score each completion against the oldest expectation
    always @(negedge CLK) begin
        exp_t e;
        if (RST === 1'b0) begin
            if (bus.iREN && !bus.iwait) begin
                if (iq.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL i_unexpected: fetch completion at %0t, none expected", $time);
                end else begin
                    e = iq.pop_front();
                    chk("iload", bus.iload, e.load);
                    chk("i_ramaddr", bus.ramaddr, e.addr);
                    chk("i_ramREN", {31'd0, bus.ramREN}, 32'd1);
                end
            end
            if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
                if (dq.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL d_unexpected: data completion at %0t, none expected", $time);
                end else begin
                    e = dq.pop_front();
                    chk("dload", bus.dload, e.load);
                    chk("d_ramaddr", bus.ramaddr, e.addr);
                    chk("d_ramWEN", {31'd0, bus.ramWEN}, {31'd0, e.wen});
                    chk("d_ramREN", {31'd0, bus.ramREN}, {31'd0, ~e.wen});
                    if (e.wen) chk("d_ramstore", bus.ramstore, e.wdata);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; errors = 0;
        RST = 1'b1;
        bus.iREN = 1'b1; bus.iaddr = 32'h0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = 32'h0; bus.dstore = 32'h0; bus.ramload = 32'h0; bus.ramstate = FREE;

        // Reset state: strobes off, waits follow IDLE rule
        tick(); tick();
        at_neg();
        chk("rst_state", st(), 32'd0);
        chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_iwait", {31'd0, bus.iwait}, 32'd1);
        chk("rst_err", {31'd0, bus.ram_err}, 32'd0);
        chk("rst_starve", sc(), 32'd0);
        tick();
        RST = 1'b0; bus.iREN = 1'b0;
        tick();

        // Lone fetch, 2-cycle access
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        iq.push_back(mk(1'b0, 32'h40, 32'h0, 32'h8C220004));
        at_neg();
        chk("f_c0_iwait", {31'd0, bus.iwait}, 32'd1);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h8C220004;
        at_neg();
        chk("f_c1_state", st(), {30'd0, IGRANT});
        chk("f_c1_iwait", {31'd0, bus.iwait}, 32'd0);
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = 32'h0;
        at_neg();
        chk("f_c2_state", st(), 32'd0);
        chk("f_c2_iload", bus.iload, 32'h0);
        tick();

        // Data priority over a simultaneous fetch
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        dq.push_back(mk(1'b1, 32'h100, 32'hDEADBEEF, 32'h11111111));
        iq.push_back(mk(1'b0, 32'h44, 32'h0, 32'h22222222));
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h11111111;
        at_neg();
        chk("p_dgrant", st(), {30'd0, DGRANT});
        chk("p_iwait_hi", {31'd0, bus.iwait}, 32'd1);
        tick();
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        at_neg();
        chk("p_idle", st(), 32'd0);
        chk("p_starve1", sc(), 32'd1);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h22222222;
        at_neg();
        chk("p_igrant", st(), {30'd0, IGRANT});
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        at_neg();
        chk("p_starve0", sc(), 32'd0);
        tick();

        // Starvation: 4 data grants, then forced fetch, then the 5th data
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1;
        for (int k = 0; k < 5; k++)
            dq.push_back(mk(1'b0, 32'h300 + 32'(4 * k), 32'h0, 32'hA0 + 32'(k)));
        iq.push_back(mk(1'b0, 32'h80, 32'h0, 32'h0000F00D));
        for (int k = 0; k < 4; k++) begin
            bus.daddr = 32'h300 + 32'(4 * k);
            at_neg();
            chk("s_idle", st(), 32'd0);
            tick();
            bus.ramstate = ACCESS; bus.ramload = 32'hA0 + 32'(k);
            at_neg();
            chk("s_dgrant", st(), {30'd0, DGRANT});
            tick();
            bus.ramstate = FREE;
        end
        bus.daddr = 32'h310;
        at_neg();
        chk("s_sat", sc(), 32'd4);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h0000F00D;
        at_neg();
        chk("s_forced_igrant", st(), {30'd0, IGRANT});
        chk("s_dwait_hi", {31'd0, bus.dwait}, 32'd1);
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        at_neg();
        chk("s_starve_clr", sc(), 32'd0);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hA4;
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        tick();

        // Wait states and error on a data read
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        dq.push_back(mk(1'b0, 32'h200, 32'h0, 32'h5555AAAA));
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.ramstate = (k == 2) ? ERROR : BUSY;
            at_neg();
            chk("w_dwait_hi", {31'd0, bus.dwait}, 32'd1);
            chk("w_addr", bus.ramaddr, 32'h200);
            chk("w_err_pre", {31'd0, bus.ram_err}, 32'd0);
            tick();
        end
        bus.ramstate = ACCESS; bus.ramload = 32'h5555AAAA;
        at_neg();
        chk("w_err_set", {31'd0, bus.ram_err}, 32'd1);
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        at_neg();
        chk("w_err_sticky", {31'd0, bus.ram_err}, 32'd1);
        tick();

        // Withdrawal of a data read during BUSY, pending fetch then served
        bus.dREN = 1'b1; bus.daddr = 32'h240; bus.iREN = 1'b1; bus.iaddr = 32'h84;
        iq.push_back(mk(1'b0, 32'h84, 32'h0, 32'h00000077));
        tick();
        bus.ramstate = BUSY;
        tick();
        bus.dREN = 1'b0;
        at_neg();
        chk("x_dwait_hi", {31'd0, bus.dwait}, 32'd1);
        chk("x_ramREN_off", {31'd0, bus.ramREN}, 32'd0);
        tick();
        bus.ramstate = FREE;
        at_neg();
        chk("x_idle", st(), 32'd0);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h00000077;
        at_neg();
        chk("x_igrant", st(), {30'd0, IGRANT});
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        tick();

        // Async reset in the middle of a data write grant
        bus.iREN = 1'b1; bus.iaddr = 32'h88;
        bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h12345678;
        dq.push_back(mk(1'b1, 32'h400, 32'h12345678, 32'h0));
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h0;
        tick();
        bus.ramstate = BUSY; bus.daddr = 32'h404;
        tick();
        at_neg();
        chk("r_ramWEN_pre", {31'd0, bus.ramWEN}, 32'd1);
        chk("r_starve_pre", sc(), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("r_ramWEN_async", {31'd0, bus.ramWEN}, 32'd0);
        chk("r_ramaddr_async", bus.ramaddr, 32'h0);
        chk("r_state_async", st(), 32'd0);
        tick();
        RST = 1'b0; bus.iREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
        at_neg();
        chk("r_state", st(), 32'd0);
        chk("r_err_clr", {31'd0, bus.ram_err}, 32'd0);
        chk("r_starve_clr", sc(), 32'd0);
        tick();

        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequential arbiter that shares the single-ported unified RAM between the instruction-fetch and data-access requesters of the MIPS datapath. It sits between the fetch and load/store logic, which issue iREN and dREN/dWEN alongside the control signals, and the RAM model with its ramstate handshake. Data accesses have priority. A starvation counter guarantees fetch forward progress. Each requester sees a wait-style stall signal.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending; range 1..15.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  fetch address (word_t)
- iwait  out  1  fetch stalled; low for exactly the cycle iload is valid
- iload  out  32  fetched instruction
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- dwait  out  1  data stalled; low for exactly the completion cycle
- dload  out  32  read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ram_err  out  1  sticky, set on any ERROR response

## Operation
- States: IDLE, IGRANT, DGRANT (arb_state_t).
- From IDLE, a data request (dREN|dWEN) goes to DGRANT, and a lone iREN goes to IGRANT. Exception: when starve_cnt == STARVE_MAX and iREN is high, go to IGRANT regardless of data requests.
- IGRANT: ramREN=1, ramaddr=iaddr.
- DGRANT: ramREN=dREN&~dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. dWEN&dREN together is treated as a write.
- In IDLE all RAM strobes are 0, ramaddr and ramstore are 0, and both waits equal their own request.
- Completion happens in any grant state when ramstate==ACCESS:
  - the owner's wait goes low combinationally;
  - iload or dload = ramload;
  - next state is IDLE.
- The non-owner's wait stays high throughout the grant.
- BUSY or FREE while in a grant: hold the state and keep the strobes asserted.
- ERROR: set ram_err, keep wait high, and reissue the same request next cycle (hold state). ram_err clears only on RST.
- Request withdrawal: if the owner drops its request mid-grant, the arbiter returns to IDLE next cycle with no completion pulse.
- starve_cnt width is 4 bits, saturating at STARVE_MAX:
  - +1 on each data completion while iREN is high;
  - cleared on each instruction completion;
  - cleared on a data completion while iREN is low.
- iload and dload read 0 outside their completion cycle.

## Timing
- RST is asynchronous and forces state=IDLE, starve_cnt=0, ram_err=0.
- While RST is high, ramREN=ramWEN=0 and ramaddr=ramstore=0; waits follow the IDLE rule.
- Reset mid-grant abandons the transaction immediately and produces no completion.
- Minimum latency: request at cycle 0 → grant registered at edge 1 → strobes in cycle 1.
- If ramstate==ACCESS in cycle 1, wait is low in cycle 1, giving a 2-cycle access.
- Every completion is followed by one IDLE cycle, so back-to-back accesses occur at most every 2 cycles.
- Waits and loads are combinational from state, ramstate and ramload. Strobes, ramaddr and ramstore are combinational from state and the requester inputs.
- Simultaneous iREN and data request in IDLE with starve_cnt < STARVE_MAX: data wins, and iwait stays high until the fetch's own completion.

## Structure
- Add arb_state_t to cpu_types_pkg. ramstate_t and word_t already live there.
- Add a ram_arbiter_if interface with modports arb and tb. It mirrors the existing control-unit interface style and carries all non-clock/reset ports.
- One sub-module is natural: starve_counter, a saturating counter with inc, clr and sat outputs.
- The FSM next-state logic and output mux stay in ram_arbiter.

## Test plan
- Lone fetch: iREN=1, iaddr=0x40, ramstate ACCESS in the first grant cycle with ramload=0x8C220004 → ramREN=1 and ramaddr=0x40 in cycle 1; iwait=0 and iload=0x8C220004 in cycle 1; IDLE in cycle 2.
- Data priority: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) together → DGRANT first with ramWEN=1, ramstore=0xDEADBEEF; iwait stays high; IGRANT follows after the IDLE cycle.
- Starvation, STARVE_MAX=4: iREN held high while 5 data requests stream back-to-back → 4 data completions, then IGRANT even with dREN high; starve_cnt=0 after the fetch completes.
- Wait states and error: ramstate BUSY,BUSY,ERROR,ACCESS during a dREN grant → dwait high for 3 cycles and low in the 4th; address held at 0x200 throughout; ram_err=1 and remains 1.
- Withdrawal: dREN dropped in the second BUSY cycle → IDLE next cycle, no dwait low pulse, pending iREN then granted.
- Async reset mid-grant: RST pulsed between clock edges during DGRANT → ramWEN=0 immediately; state IDLE, ram_err=0, starve_cnt=0 after release.
